instruction_fetch_unit: RTL and testbench

- Fetch stage that reads the PC value from the address register file (OutC with OutCSel=00).
- Reads two bytes from byte-wide memory at PC and PC+1 over a req/ack handshake, assembles the 16-bit instruction, and hands it to the decoder over a valid/ready handshake.
- Pulses PCInc once per accepted byte; the control unit turns each pulse into RegSel=100 with the increment FunSel.

---
 rtl/instruction_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetches a 16-bit instruction as two byte reads at PC and PC+1, then presents it to the decoder.
// Latency: 1 cycle to issue, plus 1 cycle per byte with zero-wait memory; IRValid rises on the third edge after Start.
// Backpressure: memory stalls via MemAck (bounded by TIMEOUT); decoder stalls by holding IRReady low, and IR stays frozen.
module instruction_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    input  logic              Flush,
    input  logic [ADDR_W-1:0] PCIn,
    input  logic [7:0]        MemData,
    input  logic              MemAck,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemReq,
    output logic              PCInc,
    output logic [15:0]       IR,
    output logic              IRValid,
    input  logic              IRReady,
    output logic              Busy,
    output logic              FetchErr
);

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        VALID
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        ir_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pcinc_d;
    logic               err_d;
    logic               xfer;
    logic               timeout_hit;

    assign MemReq  = (state_q == FETCH_LO) || (state_q == FETCH_HI);
    assign IRValid = (state_q == VALID);
    assign Busy    = (state_q != IDLE);
    assign xfer    = MemReq && MemAck;

    // The edge that would bring the wait count up to TIMEOUT is the one that aborts.
    assign timeout_hit = (TIMEOUT != 0) && MemReq && !MemAck
                         && (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        ir_d    = IR;
        addr_d  = MemAddr;
        cnt_d   = cnt_q;
        pcinc_d = 1'b0;
        err_d   = 1'b0;

        if (Flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_d = FETCH_LO;
                        addr_d  = PCIn;
                        cnt_d   = '0;
                    end
                end
                FETCH_LO, FETCH_HI: begin
                    if (xfer) begin
                        pcinc_d = 1'b1;
                        cnt_d   = '0;
                        if (state_q == FETCH_LO) begin
                            ir_d[7:0] = MemData;
                            addr_d    = MemAddr + ADDR_W'(1);
                            state_d   = FETCH_HI;
                        end else begin
                            ir_d[15:8] = MemData;
                            state_d    = VALID;
                        end
                    end else if (timeout_hit) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                VALID: begin
                    if (IRReady) begin
                        if (Start) begin
                            state_d = FETCH_LO;
                            addr_d  = PCIn;
                            cnt_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= IDLE;
            IR       <= '0;
            MemAddr  <= '0;
            cnt_q    <= '0;
            PCInc    <= 1'b0;
            FetchErr <= 1'b0;
        end else begin
            state_q  <= state_d;
            IR       <= ir_d;
            MemAddr  <= addr_d;
            cnt_q    <= cnt_d;
            PCInc    <= pcinc_d;
            FetchErr <= err_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of fetch records plus flush, timeout, wrap and reset sequences.
module tb_instruction_fetch_unit;

    logic        Clock = 1'b0;
    logic        Reset, Start, Flush, MemAck, IRReady;
    logic [15:0] PCIn, MemAddr, IR;
    logic [7:0]  MemData;
    logic        MemReq, PCInc, IRValid, Busy, FetchErr;

    int checks = 0;
    int errors = 0;

    instruction_fetch_unit #(.ADDR_W(16), .TIMEOUT(15)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Flush(Flush),
        .PCIn(PCIn), .MemData(MemData), .MemAck(MemAck),
        .MemAddr(MemAddr), .MemReq(MemReq), .PCInc(PCInc),
        .IR(IR), .IRValid(IRValid), .IRReady(IRReady),
        .Busy(Busy), .FetchErr(FetchErr)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          ack_wait;
        int          rdy_delay;
        logic [15:0] exp_a0;
        logic [15:0] exp_a1;
        logic [15:0] exp_ir;
    } vec_t;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_log [$];
    int          ack_wait = 0;
    bit          mem_en   = 1'b1;
    int          wait_cnt = 0;
    int          pcinc_cnt = 0;
    int          err_cnt   = 0;
    logic        prev_req  = 1'b0;
    logic [15:0] prev_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory responder and pulse monitor share one process so their ordering is fixed.
    always @(negedge Clock) begin
        if (PCInc) pcinc_cnt++;
        if (FetchErr) err_cnt++;
        if (MemReq && prev_req && !MemAck)
            check("addr_stable", MemAddr, prev_addr);
        prev_req  = MemReq;
        prev_addr = MemAddr;
        if (MemReq && mem_en) begin
            if (wait_cnt >= ack_wait) begin
                MemAck  = 1'b1;
                MemData = mem[MemAddr];
                addr_log.push_back(MemAddr);
                wait_cnt = 0;
            end else begin
                MemAck = 1'b0;
                wait_cnt++;
            end
        end else begin
            MemAck   = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic wait_valid();
        for (int i = 0; i < 80; i++) begin
            if (IRValid) break;
            @(negedge Clock);
        end
        check("valid_wait", IRValid, 1);
    endtask

    task automatic do_fetch(input vec_t v);
        mem[v.pc]         = v.lo;
        mem[v.pc + 16'd1] = v.hi;
        ack_wait = v.ack_wait;
        mem_en   = 1'b1;
        addr_log.delete();
        @(negedge Clock);
        pcinc_cnt = 0;
        PCIn    = v.pc;
        Start   = 1'b1;
        IRReady = 1'b0;
        @(negedge Clock);
        Start = 1'b0;
        check("req_after_start", {Busy, MemReq}, 2'b11);
        check("first_addr", MemAddr, v.exp_a0);
        wait_valid();
        check("ir_value", IR, v.exp_ir);
        for (int i = 0; i < v.rdy_delay; i++) begin
            @(negedge Clock);
            check("ir_held", {IRValid, IR}, {1'b1, v.exp_ir});
        end
        IRReady = 1'b1;
        @(negedge Clock);
        IRReady = 1'b0;
        check("idle_after_accept", {IRValid, Busy, MemReq}, 3'b000);
        check("pcinc_pulses", pcinc_cnt, 2);
        check("ack_count", addr_log.size(), 2);
        if (addr_log.size() == 2) begin
            check("addr_lo", addr_log[0], v.exp_a0);
            check("addr_hi", addr_log[1], v.exp_a1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [4];
        vecs[0] = '{16'h0040, 8'h34, 8'h12, 0, 0, 16'h0040, 16'h0041, 16'h1234};
        vecs[1] = '{16'h0040, 8'h34, 8'h12, 3, 4, 16'h0040, 16'h0041, 16'h1234};
        vecs[2] = '{16'h1000, 8'hEF, 8'hBE, 1, 1, 16'h1000, 16'h1001, 16'hBEEF};
        vecs[3] = '{16'hFFFF, 8'h5A, 8'hA5, 0, 2, 16'hFFFF, 16'h0000, 16'hA55A};

        Reset = 1'b0; Start = 1'b0; Flush = 1'b0; IRReady = 1'b0; PCIn = '0;
        MemAck = 1'b0; MemData = '0;
        repeat (3) @(negedge Clock);
        check("reset_outputs", {MemReq, PCInc, IRValid, Busy, FetchErr}, 5'b0);
        check("reset_ir_addr", {IR, MemAddr}, 32'h0);
        Reset = 1'b1;

        foreach (vecs[i]) do_fetch(vecs[i]);

        // Back-to-back with wrap: Start held, PCIn updated as the control unit would.
        mem[16'hFFFF] = 8'h5A; mem[16'h0000] = 8'hA5;
        mem[16'h0001] = 8'h11; mem[16'h0002] = 8'h22;
        ack_wait = 0;
        addr_log.delete();
        @(negedge Clock);
        pcinc_cnt = 0;
        PCIn = 16'hFFFF; Start = 1'b1; IRReady = 1'b1;
        wait_valid();
        check("b2b_ir0", IR, 16'hA55A);
        PCIn = 16'h0001;
        @(negedge Clock);
        Start = 1'b0;
        check("b2b_no_idle", {Busy, MemReq, IRValid}, 3'b110);
        check("b2b_addr", MemAddr, 16'h0001);
        wait_valid();
        check("b2b_ir1", IR, 16'h2211);
        @(negedge Clock);
        IRReady = 1'b0;
        check("b2b_idle", Busy, 0);
        check("b2b_pcinc", pcinc_cnt, 4);
        check("b2b_acks", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check("b2b_wrap_addr", addr_log[1], 16'h0000);
            check("b2b_last_addr", addr_log[3], 16'h0002);
        end

        // Flush coinciding with the high-byte ack.
        mem[16'h0040] = 8'h34; mem[16'h0041] = 8'h12;
        ack_wait = 2;
        @(negedge Clock);
        pcinc_cnt = 0;
        PCIn = 16'h0040; Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            #1;
            if (MemAck && MemAddr == 16'h0041) break;
        end
        check("flush_hi_ack_seen", {MemAck, MemAddr}, {1'b1, 16'h0041});
        Flush = 1'b1;
        @(negedge Clock);
        Flush = 1'b0;
        check("flush_state", {Busy, MemReq, IRValid}, 3'b000);
        @(negedge Clock);
        check("flush_pcinc", pcinc_cnt, 1);

        // Timeout: memory never answers.
        mem_en = 1'b0;
        err_cnt = 0;
        @(negedge Clock);
        pcinc_cnt = 0;
        PCIn = 16'h0200; Start = 1'b1;
        @(posedge Clock);
        #1 Start = 1'b0;
        repeat (14) @(posedge Clock);
        @(negedge Clock);
        check("timeout_before", {FetchErr, MemReq}, 2'b01);
        @(posedge Clock);
        @(negedge Clock);
        check("timeout_err", {FetchErr, Busy, MemReq}, 3'b100);
        @(negedge Clock);
        check("timeout_pulse_len", err_cnt, 1);
        check("timeout_no_pcinc", pcinc_cnt, 0);
        mem_en = 1'b1;

        // Reset while holding a valid instruction.
        mem[16'h0080] = 8'hCD; mem[16'h0081] = 8'hAB;
        ack_wait = 0;
        @(negedge Clock);
        PCIn = 16'h0080; Start = 1'b1; IRReady = 1'b0;
        @(negedge Clock);
        Start = 1'b0;
        wait_valid();
        check("pre_reset_ir", IR, 16'hABCD);
        Reset = 1'b0;
        @(negedge Clock);
        check("midreset_ir_addr", {IR, MemAddr}, 32'h0);
        check("midreset_outputs", {MemReq, PCInc, IRValid, Busy, FetchErr}, 5'b0);
        Reset = 1'b1;
        do_fetch(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
